// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory bus between the fetch and data ports.
// Build option MEM_ARBITER_RR_EN selects round-robin on contention. Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        flush_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_IF  = 2'd1;
    localparam logic [1:0] S_BUSY_MEM = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [3:0]  bus_sel_q,   bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_ack_q,    if_ack_d;
    logic        mem_ack_q,   mem_ack_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        flush_q,     flush_d;
    logic        pick_if;
    logic        grant_if;
    logic        grant_mem;

`ifdef MEM_ARBITER_RR_EN
    // ptr_q=1 means the fetch port wins the next contested grant
    logic        ptr_q,       ptr_d;
    logic        contested_q, contested_d;
    assign pick_if = ptr_q;
`else
    assign pick_if = 1'b0;
`endif

    // No grant in a cycle where an ack is visible: the acked requester still
    // shows req that cycle and must not be served twice.
    assign grant_mem = (state_q == S_IDLE) && !flush_i && !if_ack_q && !mem_ack_q
                       && mem_req_i && (!if_req_i || !pick_if);
    assign grant_if  = (state_q == S_IDLE) && !flush_i && !if_ack_q && !mem_ack_q
                       && if_req_i && !grant_mem;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        flush_d     = flush_q;
`ifdef MEM_ARBITER_RR_EN
        ptr_d       = ptr_q;
        contested_d = contested_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    state_d     = S_BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_sel_d   = mem_sel_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (grant_if) begin
                    state_d     = S_BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_sel_d   = 4'hF;
                    bus_wdata_d = 32'd0;
                end
`ifdef MEM_ARBITER_RR_EN
                contested_d = if_req_i && mem_req_i;
`endif
            end
            S_BUSY_IF, S_BUSY_MEM: begin
                if (bus_ack_i) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    flush_d   = 1'b0;
                    // A flushed transaction completes on the bus but stays invisible
                    if (!(flush_q || flush_i)) begin
                        if (state_q == S_BUSY_MEM) begin
                            mem_ack_d   = 1'b1;
                            mem_rdata_d = bus_rdata_i;
                        end else begin
                            if_ack_d    = 1'b1;
                            if_rdata_d  = bus_rdata_i;
                        end
`ifdef MEM_ARBITER_RR_EN
                        if (contested_q) begin
                            ptr_d = (state_q == S_BUSY_MEM);
                        end
`endif
                    end
                end else if (flush_i) begin
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            flush_q     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            ptr_q       <= 1'b0;
            contested_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            flush_q     <= flush_d;
`ifdef MEM_ARBITER_RR_EN
            ptr_q       <= ptr_d;
            contested_q <= contested_d;
`endif
        end
    end

    assign if_ack_o       = if_ack_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_ack_o      = mem_ack_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign stallreq_if_o  = if_req_i & ~if_ack_q;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        flush_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_sel_i      (mem_sel_i),
        .mem_wdata_i    (mem_wdata_i),
        .if_ack_o       (if_ack_o),
        .if_rdata_o     (if_rdata_o),
        .mem_ack_o      (mem_ack_o),
        .mem_rdata_o    (mem_rdata_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_sel_o      (bus_sel_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .flush_i        (flush_i),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_addr [4];
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0;
        mem_sel_i = 4'd0; mem_wdata_i = 32'd0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0; flush_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_we", bus_we_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_sel", bus_sel_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        chk("rst_acks", {if_ack_o, mem_ack_o}, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_mem_rdata", mem_rdata_o, 0);

        // fetch only, ack on first BUSY cycle
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        #1 chk("f_stall", stallreq_if_o, 1);
        tick();
        chk("f_bus_req", bus_req_o, 1);
        chk("f_bus_we", bus_we_o, 0);
        chk("f_bus_sel", bus_sel_o, 4'hF);
        chk("f_bus_addr", bus_addr_o, 32'h0000_0100);
        chk("f_bus_wdata", bus_wdata_o, 0);
        chk("f_if_ack_early", if_ack_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
        tick();
        chk("f_if_ack", if_ack_o, 1);
        chk("f_if_rdata", if_rdata_o, 32'h2402_0005);
        chk("f_bus_req_drop", bus_req_o, 0);
        chk("f_stall_ack", stallreq_if_o, 0);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("f_if_ack_pulse", if_ack_o, 0);
        chk("f_bus_req_idle", bus_req_o, 0);

        // stray bus ack in IDLE
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_DEAD;
        tick();
        chk("idle_ack_acks", {if_ack_o, mem_ack_o}, 0);
        chk("idle_ack_if_rdata", if_rdata_o, 32'h2402_0005);
        chk("idle_ack_mem_rdata", mem_rdata_o, 0);
        bus_ack_i = 1'b0;

        // store with 3 wait states
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0040;
        mem_sel_i = 4'b0011; mem_wdata_i = 32'h0000_BEEF; bus_rdata_i = 32'h1234_5678;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_bus_req", bus_req_o, 1);
            chk("st_bus_we", bus_we_o, 1);
            chk("st_bus_addr", bus_addr_o, 32'h0000_0040);
            chk("st_bus_sel", bus_sel_o, 4'b0011);
            chk("st_bus_wdata", bus_wdata_o, 32'h0000_BEEF);
            chk("st_stall", stallreq_mem_o, 1);
            chk("st_ack_early", mem_ack_o, 0);
            if (i == 3) bus_ack_i = 1'b1;
            tick();
        end
        chk("st_mem_ack", mem_ack_o, 1);
        chk("st_mem_rdata", mem_rdata_o, 32'h1234_5678);
        chk("st_stall_ack", stallreq_mem_o, 0);
        chk("st_bus_req_drop", bus_req_o, 0);
        mem_req_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("st_ack_pulse", mem_ack_o, 0);
        chk("st_if_rdata_hold", if_rdata_o, 32'h2402_0005);

        // simultaneous requests: data port first, then fetch
        if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0080; mem_sel_i = 4'hF; mem_wdata_i = 32'd0;
        tick();
        chk("sim_first_addr", bus_addr_o, 32'h0000_0080);
        chk("sim_if_stall", stallreq_if_o, 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_0001;
        tick();
        chk("sim_mem_ack", mem_ack_o, 1);
        chk("sim_if_ack_none", if_ack_o, 0);
        chk("sim_mem_rdata", mem_rdata_o, 32'hAAAA_0001);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("sim_no_grant_ack_cycle", bus_req_o, 0);
        tick();
        chk("sim_if_grant", bus_req_o, 1);
        chk("sim_if_addr", bus_addr_o, 32'h0000_0200);
        chk("sim_if_sel", bus_sel_o, 4'hF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        tick();
        chk("sim_if_ack", if_ack_o, 1);
        chk("sim_if_rdata", if_rdata_o, 32'h5555_AAAA);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // flush in 2nd BUSY cycle of a load, ack in 4th
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0300;
        tick();
        chk("fl_bus_req", bus_req_o, 1);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_not_aborted", bus_req_o, 1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
        tick();
        chk("fl_mem_ack", mem_ack_o, 0);
        chk("fl_mem_rdata", mem_rdata_o, 32'hAAAA_0001);
        chk("fl_bus_req_drop", bus_req_o, 0);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("fl_idle_bus_req", bus_req_o, 0);
        chk("fl_no_late_ack", mem_ack_o, 0);

        // flush in IDLE blocks the grant
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400; flush_i = 1'b1;
        tick();
        chk("fi_blocked", bus_req_o, 0);
        flush_i = 1'b0;
        tick();
        chk("fi_granted", bus_req_o, 1);

        // reset during BUSY_IF, late bus ack
        rst = 1'b1; if_req_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("rb_bus_req", bus_req_o, 0);
        chk("rb_bus_addr", bus_addr_o, 0);
        chk("rb_bus_sel", bus_sel_o, 0);
        chk("rb_if_rdata", if_rdata_o, 0);
        chk("rb_mem_rdata", mem_rdata_o, 0);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_0000;
        tick();
        chk("rb_late_if_ack", if_ack_o, 0);
        chk("rb_late_rdata", if_rdata_o, 0);
        chk("rb_late_bus_req", bus_req_o, 0);
        bus_ack_i = 1'b0;
        tick();

        // both ports requesting continuously
`ifdef MEM_ARBITER_RR_EN
        exp_addr[0] = 32'h0000_0500; exp_addr[1] = 32'h0000_0600;
        exp_addr[2] = 32'h0000_0500; exp_addr[3] = 32'h0000_0600;
`else
        exp_addr[0] = 32'h0000_0500; exp_addr[1] = 32'h0000_0500;
        exp_addr[2] = 32'h0000_0500; exp_addr[3] = 32'h0000_0500;
`endif
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0500; mem_sel_i = 4'hF;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!bus_req_o && n < 8) begin
                tick();
                n++;
            end
            chk("rr_grant_seen", bus_req_o, 1);
            chk("rr_grant_addr", bus_addr_o, exp_addr[k]);
            bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_1000 + k;
            tick();
            bus_ack_i = 1'b0;
            chk("rr_ack_port", {mem_ack_o, if_ack_o},
                (exp_addr[k] == 32'h0000_0500) ? 32'd2 : 32'd1);
        end
        mem_req_i = 1'b0; if_req_i = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: if_req_i  input  1; if_addr_i  input  32.  Fetch request, always read, full word.
REQ-004 SHALL have ports: mem_req_i  input  1; mem_we_i  input  1; mem_addr_i  input  32; mem_sel_i  input  4; mem_wdata_i  input  32.  Data-port request.
REQ-005 SHALL have ports: if_ack_o  output  1; if_rdata_o  output  32; mem_ack_o  output  1; mem_rdata_o  output  32.  One-cycle ack pulse plus registered read data.
REQ-006 SHALL have ports: bus_req_o  output  1; bus_we_o  output  1; bus_addr_o  output  32; bus_sel_o  output  4; bus_wdata_o  output  32; bus_ack_i  input  1; bus_rdata_i  input  32.  Single shared memory bus.
REQ-007 SHALL have ports: flush_i  input  1  pipeline flush; stallreq_if_o  output  1; stallreq_mem_o  output  1.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM.
REQ-009 IDLE: when a request is present and flush_i=0, the FSM SHALL latch the winner's we/addr/sel/wdata into bus registers and move to BUSY_IF or BUSY_MEM; bus_req_o=1 from the next cycle.
REQ-010 For fetch grants, bus_we_o SHALL be 0, bus_sel_o 4'b1111, and bus_wdata_o 0.
REQ-011 Bus outputs SHALL stay constant while bus_req_o=1 and bus_ack_i=0, with an unlimited number of wait states.
REQ-012 On the edge where bus_ack_i=1 in BUSY_x, the FSM SHALL drop bus_req_o, return to IDLE, pulse x_ack_o for exactly one cycle, and register bus_rdata_i into x_rdata_o (writes also update it).
REQ-013 x_rdata_o SHALL hold its value until the next ack to the same port.
REQ-014 Requesters hold req and payload stable until they sample ack=1 and deassert req on that same edge. The arbiter SHALL NOT grant during the ack cycle, so the minimum turnaround is 2 cycles: request in IDLE, bus_ack in the first BUSY cycle, ack visible on the next cycle.
REQ-015 Default priority when both request in IDLE: data port wins; fetch is granted on the next IDLE cycle.
REQ-016 stallreq_if_o SHALL equal if_req_i & ~if_ack_o; stallreq_mem_o SHALL equal mem_req_i & ~mem_ack_o (combinational).
REQ-017 flush_i=1 in IDLE SHALL block any grant that cycle.
REQ-018 flush_i=1 in BUSY SHALL NOT abort the bus cycle, which completes normally; the port ack for that transaction SHALL be suppressed, rdata SHALL NOT update, and the FSM SHALL return to IDLE.
REQ-019 A flush seen at any cycle of a BUSY transaction SHALL be remembered in a sticky bit until that transaction completes.
REQ-020 bus_ack_i while in IDLE SHALL be ignored.
REQ-021 Requests arriving during BUSY SHALL wait; stallreq stays asserted for them.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0, both acks 0, both rdata 0, flush-sticky 0, priority pointer=data.
REQ-023 Reset mid-transaction SHALL abandon the bus cycle immediately (bus_req_o=0 next cycle); a late bus_ack_i SHALL be ignored per REQ-020.

Configuration
REQ-024 Macro MEM_ARBITER_RR_EN defined: on simultaneous requests the winner SHALL alternate via a 1-bit pointer that flips to the other port after each completed grant to a port; the pointer is unaffected by single-requester grants and flushed grants.
REQ-025 MEM_ARBITER_RR_EN undefined: fixed data-port priority per REQ-015, and no pointer register exists.

Verification
REQ-026 Fetch only: if_req=1, addr=0x0000_0100, bus_ack on the 1st BUSY cycle with rdata=0x2402_0005 -> bus_req high 1 cycle, bus_we=0, sel=F, if_ack pulse in cycle 3, if_rdata=0x2402_0005.
REQ-027 Store with 3 wait states: mem_we=1, addr=0x0000_0040, sel=4'b0011, wdata=0x0000_BEEF -> bus outputs stable for 4 cycles, mem_ack 1 cycle after bus_ack, stallreq_mem high until the ack cycle.
REQ-028 Simultaneous if_req and mem_req, fixed priority: mem served first, then if; with MEM_ARBITER_RR_EN and repeated simultaneous requests, the grant order is mem, if, mem, if.
REQ-029 flush_i pulsed in the 2nd cycle of a BUSY_MEM load with bus_ack in the 4th cycle -> bus cycle completes, mem_ack stays 0, mem_rdata unchanged, FSM returns to IDLE.
REQ-030 rst asserted during BUSY_IF with bus_ack arriving 2 cycles later -> bus_req=0 after reset, late ack ignored, no if_ack, all outputs 0.
